xbar_varlat_1_to_n: RTL and testbench



---
 rtl/xbar_varlat_1_to_n.sv | 208 ++++++++++++++++++++
 tb/tb_xbar_varlat_1_to_n.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xbar_varlat_1_to_n.sv
// One OBI master fanned out to XBAR_NSLAVE slaves by address decode; an in-order index FIFO
// routes responses from variable-latency slaves. Define XBAR_VARLAT_ASSERT_EN for simulation checks.
module xbar_varlat_1_to_n #(
    parameter int XBAR_NSLAVE     = 2,
    parameter int NUM_RULES       = 1,
    parameter int MAX_OUTSTANDING = 4,
    localparam int IDX_WIDTH      = (XBAR_NSLAVE > 1) ? $clog2(XBAR_NSLAVE) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [96*NUM_RULES-1:0]     addr_map_i,
    input  logic [IDX_WIDTH-1:0]        default_idx_i,
    input  logic                        m_req_i,
    input  logic                        m_we_i,
    input  logic [3:0]                  m_be_i,
    input  logic [31:0]                 m_addr_i,
    input  logic [31:0]                 m_wdata_i,
    output logic                        m_gnt_o,
    output logic                        m_rvalid_o,
    output logic [31:0]                 m_rdata_o,
    output logic [XBAR_NSLAVE-1:0]      s_req_o,
    output logic [XBAR_NSLAVE-1:0]      s_we_o,
    output logic [4*XBAR_NSLAVE-1:0]    s_be_o,
    output logic [32*XBAR_NSLAVE-1:0]   s_addr_o,
    output logic [32*XBAR_NSLAVE-1:0]   s_wdata_o,
    input  logic [XBAR_NSLAVE-1:0]      s_gnt_i,
    input  logic [XBAR_NSLAVE-1:0]      s_rvalid_i,
    input  logic [32*XBAR_NSLAVE-1:0]   s_rdata_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    logic                 match_s;
    logic [31:0]          hit_idx_s;
    logic [IDX_WIDTH-1:0] sel_s;
    logic [IDX_WIDTH-1:0] head_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 head_rvalid_s;
    logic [31:0]          head_rdata_s;

    logic [IDX_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Address decode: lowest-index matching rule wins, out-of-range targets fall back to default then 0.
    always_comb begin
        match_s   = 1'b0;
        hit_idx_s = 32'd0;
        for (int r = 0; r < NUM_RULES; r++) begin
            if (!match_s && (m_addr_i >= addr_map_i[96*r+32 +: 32]) && (m_addr_i < addr_map_i[96*r +: 32])) begin
                match_s   = 1'b1;
                hit_idx_s = addr_map_i[96*r+64 +: 32];
            end else begin
                match_s   = match_s;
                hit_idx_s = hit_idx_s;
            end
        end
        if (match_s && (hit_idx_s < 32'(XBAR_NSLAVE))) begin
            sel_s = hit_idx_s[IDX_WIDTH-1:0];
        end else if (32'(default_idx_i) < 32'(XBAR_NSLAVE)) begin
            sel_s = default_idx_i;
        end else begin
            sel_s = '0;
        end
    end

    assign full_s  = (cnt_q == MAX_CNT);
    assign empty_s = (cnt_q == '0);
    assign head_s  = fifo_q[rptr_q];

    assign s_we_o    = {XBAR_NSLAVE{m_we_i}};
    assign s_be_o    = {XBAR_NSLAVE{m_be_i}};
    assign s_addr_o  = {XBAR_NSLAVE{m_addr_i}};
    assign s_wdata_o = {XBAR_NSLAVE{m_wdata_i}};

    // Request path: forward only to the selected slave; rst_i also masks so nothing leaks during reset.
    always_comb begin
        for (int i = 0; i < XBAR_NSLAVE; i++) begin
            s_req_o[i] = m_req_i & ~full_s & ~rst_i & (sel_s == IDX_WIDTH'(i));
        end
        m_gnt_o = m_req_i & ~full_s & ~rst_i & s_gnt_i[sel_s];
    end

    // Response path: only the slave at the FIFO head may answer.
    always_comb begin
        head_rvalid_s = 1'b0;
        head_rdata_s  = 32'd0;
        for (int i = 0; i < XBAR_NSLAVE; i++) begin
            if (head_s == IDX_WIDTH'(i)) begin
                head_rvalid_s = s_rvalid_i[i];
                head_rdata_s  = s_rdata_i[32*i +: 32];
            end else begin
                head_rvalid_s = head_rvalid_s;
                head_rdata_s  = head_rdata_s;
            end
        end
        m_rvalid_o = ~empty_s & head_rvalid_s;
        m_rdata_o  = empty_s ? 32'd0 : head_rdata_s;
    end

    assign push_s = m_req_i & m_gnt_o;
    assign pop_s  = m_rvalid_o;

    // FIFO pointer/count next state; full and empty gate push/pop so count cannot wrap.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_s) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= (push_s && (wptr_q == PTR_W'(i))) ? sel_s : fifo_q[i];
            end
        end
    end

`ifdef XBAR_VARLAT_ASSERT_EN
    xbar_varlat_1_to_n_chk #(
        .XBAR_NSLAVE (XBAR_NSLAVE),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .m_req_i    (m_req_i),
        .m_gnt_i    (m_gnt_o),
        .push_i     (push_s),
        .full_i     (full_s),
        .empty_i    (empty_s),
        .head_i     (head_s),
        .s_rvalid_i (s_rvalid_i)
    );
`endif

endmodule

`ifdef XBAR_VARLAT_ASSERT_EN
// Protocol checker for the fan-out; simulation only.
module xbar_varlat_1_to_n_chk #(
    parameter int XBAR_NSLAVE = 2,
    parameter int IDX_WIDTH   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_req_i,
    input  logic                   m_gnt_i,
    input  logic                   push_i,
    input  logic                   full_i,
    input  logic                   empty_i,
    input  logic [IDX_WIDTH-1:0]   head_i,
    input  logic [XBAR_NSLAVE-1:0] s_rvalid_i
);
    logic        pend_q;
    logic [63:0] cyc_q;

    // Cycle-by-cycle protocol checks.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            cyc_q  <= 64'd0;
        end else begin
            cyc_q  <= cyc_q + 64'd1;
            pend_q <= m_req_i & ~m_gnt_i;
            if (push_i && full_i) $error("xbar: push while full, cycle %0d t=%0t", cyc_q, $time);
            if ((|s_rvalid_i) && empty_i) $error("xbar: rvalid while empty, cycle %0d t=%0t", cyc_q, $time);
            if (pend_q && !m_req_i) $error("xbar: req dropped before gnt, cycle %0d t=%0t", cyc_q, $time);
            for (int i = 0; i < XBAR_NSLAVE; i++) begin
                if (s_rvalid_i[i] && !empty_i && (head_i != IDX_WIDTH'(i)))
                    $error("xbar: rvalid from non-head slave %0d, cycle %0d t=%0t", i, cyc_q, $time);
            end
        end
    end
endmodule
`endif

// File: tb/tb_xbar_varlat_1_to_n.sv
// Directed bench for xbar_varlat_1_to_n: decode, in-order routing, full handling and reset.
module tb_xbar_varlat_1_to_n;
    localparam int NS = 2;
    localparam int NR = 1;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [95:0]   addr_map;
    logic [0:0]    default_idx;
    logic          m_req, m_we;
    logic [3:0]    m_be;
    logic [31:0]   m_addr, m_wdata;
    logic          m_gnt, m_rvalid;
    logic [31:0]   m_rdata;
    logic [NS-1:0] s_req, s_we, s_gnt, s_rvalid;
    logic [4*NS-1:0]  s_be;
    logic [32*NS-1:0] s_addr, s_wdata, s_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    xbar_varlat_1_to_n #(.XBAR_NSLAVE(NS), .NUM_RULES(NR), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_i(rst), .addr_map_i(addr_map), .default_idx_i(default_idx),
        .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] next_exp();
        if (exp_q.size() == 0) return 32'hxxxx_xxxx;
        return exp_q.pop_front();
    endfunction

    task automatic issue(input logic [31:0] addr, input int slv, input logic [31:0] data);
        m_req = 1'b1;
        m_addr = addr;
        s_gnt = NS'(1 << slv);
        @(negedge clk);
        chk("issue_gnt", 64'(m_gnt), 64'd1);
        chk("issue_sreq", 64'(s_req), 64'(1 << slv));
        exp_q.push_back(data);
        @(posedge clk); #1;
        m_req = 1'b0;
        s_gnt = '0;
    endtask

    task automatic respond(input int slv, input logic [31:0] data, input logic exp_valid);
        s_rvalid = NS'(1 << slv);
        s_rdata = {NS{32'h5555_5555}};
        s_rdata[slv*32 +: 32] = data;
        @(negedge clk);
        chk("resp_rvalid", 64'(m_rvalid), 64'(exp_valid));
        if (exp_valid) chk("resp_rdata", 64'(m_rdata), 64'(next_exp()));
        @(posedge clk); #1;
        s_rvalid = '0;
    endtask

    typedef struct { logic [31:0] addr; logic [NS-1:0] sreq; } dec_t;
    dec_t dec_tab [5] = '{
        '{32'h2000_0004, 2'b10}, '{32'h0000_0100, 2'b01}, '{32'h2FFF_FFFC, 2'b10},
        '{32'h3000_0000, 2'b01}, '{32'h1FFF_FFFC, 2'b01}
    };

    initial begin
        rst = 1'b1;
        addr_map = {32'd1, 32'h2000_0000, 32'h3000_0000};
        default_idx = 1'b0;
        m_req = 1'b1; m_we = 1'b1; m_be = 4'hA; m_addr = 32'h2000_0004; m_wdata = 32'h0BAD_F00D;
        s_gnt = 2'b11; s_rvalid = 2'b11; s_rdata = {32'h1111_1111, 32'h2222_2222};

        // reset state
        @(negedge clk);
        chk("rst_gnt", 64'(m_gnt), 64'd0);
        chk("rst_sreq", 64'(s_req), 64'd0);
        chk("rst_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_rdata", 64'(m_rdata), 64'd0);
        chk("bcast_addr", s_addr, {2{32'h2000_0004}});
        chk("bcast_misc", 64'({s_we, s_be}), 64'({2'b11, 8'hAA}));
        @(posedge clk); #1;
        rst = 1'b0; s_gnt = '0; s_rvalid = '0;

        // decode with no grant: nothing is pushed
        foreach (dec_tab[i]) begin
            m_addr = dec_tab[i].addr;
            @(negedge clk);
            chk("decode_sreq", 64'(s_req), 64'(dec_tab[i].sreq));
            chk("decode_nognt", 64'(m_gnt), 64'd0);
        end
        default_idx = 1'b1; m_addr = 32'h0000_0100;
        @(negedge clk);
        chk("default_idx1", 64'(s_req), 64'(2'b10));
        addr_map = {32'd5, 32'h2000_0000, 32'h3000_0000}; m_addr = 32'h2000_0004;
        @(negedge clk);
        chk("oob_rule_def1", 64'(s_req), 64'(2'b10));
        default_idx = 1'b0;
        @(negedge clk);
        chk("oob_rule_def0", 64'(s_req), 64'(2'b01));
        addr_map = {32'd1, 32'h2000_0000, 32'h3000_0000};
        @(posedge clk); #1;
        m_req = 1'b0;

        // variable latency: rvalid 5 cycles after grant
        issue(32'h2000_0004, 1, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lat_wait", 64'(m_rvalid), 64'd0);
            @(posedge clk); #1;
        end
        respond(1, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        chk("lat_after_rvalid", 64'(m_rvalid), 64'd0);
        chk("lat_empty_rdata", 64'(m_rdata), 64'd0);
        @(posedge clk); #1;

        // back-to-back, in order, early non-head rvalid ignored
        issue(32'h2000_0010, 1, 32'hAAAA_1111);
        issue(32'h0000_0200, 0, 32'hBBBB_0000);
        respond(0, 32'hBBBB_0000, 1'b0);
        respond(1, 32'hAAAA_1111, 1'b1);
        respond(0, 32'hBBBB_0000, 1'b1);

        // same-cycle push and pop
        issue(32'h2000_0020, 1, 32'hCAFE_0001);
        m_req = 1'b1; m_addr = 32'h0000_0300; s_gnt = 2'b01;
        s_rvalid = 2'b10; s_rdata = {32'hCAFE_0001, 32'h5555_5555};
        @(negedge clk);
        chk("pp_gnt", 64'(m_gnt), 64'd1);
        chk("pp_rvalid", 64'(m_rvalid), 64'd1);
        chk("pp_rdata", 64'(m_rdata), 64'(next_exp()));
        exp_q.push_back(32'hCAFE_0002);
        @(posedge clk); #1;
        m_req = 1'b0; s_gnt = '0; s_rvalid = '0;
        respond(0, 32'hCAFE_0002, 1'b1);

        // fill to MAX_OUTSTANDING, then grant only a cycle after a pop
        for (int i = 0; i < MO; i++) issue(32'h0000_0100 + 32'(4*i), 0, 32'hC000_0000 + 32'(i));
        m_req = 1'b1; m_addr = 32'h0000_0100; s_gnt = 2'b01;
        @(negedge clk);
        chk("full_gnt", 64'(m_gnt), 64'd0);
        chk("full_sreq", 64'(s_req), 64'd0);
        @(posedge clk); #1;
        s_rvalid = 2'b01; s_rdata = {32'h5555_5555, 32'hC000_0000};
        @(negedge clk);
        chk("full_pop_rvalid", 64'(m_rvalid), 64'd1);
        chk("full_pop_rdata", 64'(m_rdata), 64'(next_exp()));
        chk("full_pop_nogrant", 64'(m_gnt), 64'd0);
        @(posedge clk); #1;
        s_rvalid = '0;
        @(negedge clk);
        chk("fifth_gnt", 64'(m_gnt), 64'd1);
        chk("fifth_sreq", 64'(s_req), 64'(2'b01));
        exp_q.push_back(32'hC000_0004);
        @(posedge clk); #1;
        m_req = 1'b0; s_gnt = '0;
        for (int i = 1; i <= MO; i++) respond(0, 32'hC000_0000 + 32'(i), 1'b1);

        // reset with two outstanding drops them
        issue(32'h2000_0004, 1, 32'h1234_0001);
        issue(32'h0000_0100, 0, 32'h1234_0002);
        exp_q.delete();
        rst = 1'b1; s_rvalid = 2'b10; s_rdata = {32'h1234_0001, 32'h1234_0002};
        @(negedge clk);
        chk("midrst_rvalid", 64'(m_rvalid), 64'd0);
        chk("midrst_rdata", 64'(m_rdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_rvalid", 64'(m_rvalid), 64'd0);
        chk("postrst_rdata", 64'(m_rdata), 64'd0);
        @(posedge clk); #1;
        s_rvalid = '0;
        issue(32'h2000_0004, 1, 32'h8765_4321);
        respond(1, 32'h8765_4321, 1'b1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
